// File: rtl/debug_trace_buffer_if.sv
// Bus bundle for the debug trace buffer: core writeback capture port, trace
// output stream and status. The design side uses the slave modport.
interface debug_trace_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
);
  logic                     debug_reg_write_en;
  logic [4:0]               debug_reg_write_addr;
  logic [31:0]              debug_reg_write_data;
  logic [31:0]              debug_pc_addr;

  // Stream: the head record transfers on a rising edge where out_valid and
  // out_ready are both 1; while out_valid=1 and out_ready=0 the head holds.
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [4:0]               out_addr;
  logic [31:0]              out_data;

  logic [$clog2(DEPTH):0]   level;
  logic [DROP_W-1:0]        drop_count;
  logic                     halt;
  logic [1:0]               dbg_state;

  modport master (
    output debug_reg_write_en, debug_reg_write_addr, debug_reg_write_data,
           debug_pc_addr, out_ready,
    input  out_valid, out_pc, out_addr, out_data, level, drop_count, halt,
           dbg_state
  );

  modport slave (
    input  debug_reg_write_en, debug_reg_write_addr, debug_reg_write_data,
           debug_pc_addr, out_ready,
    output out_valid, out_pc, out_addr, out_data, level, drop_count, halt,
           dbg_state
  );
endinterface

// File: rtl/debug_trace_buffer.sv
// Captures architectural register writes into a FWFT FIFO, drains them over a
// valid/ready stream, and raises halt once the end-of-program sentinel drains.
module debug_trace_buffer #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] HALT_DATA = 32'habcd0000,
  parameter int          DROP_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  debug_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              halt_q, halt_d;

  logic [31:0]       pc_mem   [DEPTH];
  logic [4:0]        addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic              capture, full, valid, pop, push, drop;

  always_comb begin
    valid    = (level_q != '0);
    full     = (level_q == LW'(DEPTH));
    capture  = bus.debug_reg_write_en && (bus.debug_reg_write_addr != 5'd0) &&
               (state_q == ST_RUN);
    pop      = valid && bus.out_ready;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    push     = capture && (!full || pop);
    drop     = capture && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    drop_d   = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;

    state_d  = state_q;
    halt_d   = halt_q;
    case (state_q)
      ST_RUN: begin
        // The sentinel ends capture even if it was itself dropped for overflow.
        if (capture && (bus.debug_reg_write_data == HALT_DATA)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (level_q == '0) begin
          state_d = ST_DONE;
          halt_d  = 1'b1;
        end
      end
      ST_DONE:  halt_d = 1'b1;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      halt_q   <= halt_d;
    end
  end

  // Storage needs no reset: the head fields are masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr_q]   <= bus.debug_pc_addr;
      addr_mem[wr_ptr_q] <= bus.debug_reg_write_addr;
      data_mem[wr_ptr_q] <= bus.debug_reg_write_data;
    end
  end

  assign bus.out_valid  = valid;
  assign bus.out_pc     = valid ? pc_mem[rd_ptr_q]   : 32'd0;
  assign bus.out_addr   = valid ? addr_mem[rd_ptr_q] : 5'd0;
  assign bus.out_data   = valid ? data_mem[rd_ptr_q] : 32'd0;
  assign bus.level      = level_q;
  assign bus.drop_count = drop_q;
  assign bus.halt       = halt_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer: drivers push expected records into a
// queue, a negedge monitor pops and compares every accepted head record.
module tb_debug_trace_buffer;
  localparam int          DEPTH     = 16;
  localparam int          DROP_W    = 16;
  localparam logic [31:0] HALT_DATA = 32'habcd0000;
  localparam int          RW        = 69;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [RW-1:0] exp_q[$];

  debug_trace_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  debug_trace_buffer #(.DEPTH(DEPTH), .HALT_DATA(HALT_DATA), .DROP_W(DROP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Monitor: a head with out_valid && out_ready at negedge is consumed next edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_unexpected: got %0h required no record",
                 {bus.out_pc, bus.out_addr, bus.out_data});
      end else begin
        chk("pop_order", 72'({bus.out_pc, bus.out_addr, bus.out_data}), 72'(exp_q.pop_front()));
      end
    end
  end

  // Drivers: every task starts and ends 1 time unit after a rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                    input bit keep);
    bus.debug_reg_write_en   = 1'b1;
    bus.debug_reg_write_addr = a;
    bus.debug_reg_write_data = d;
    bus.debug_pc_addr        = pc;
    if (keep) exp_q.push_back({pc, a, d});
    @(posedge clk); #1;
    bus.debug_reg_write_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    bus.out_ready = 1'b1;
    for (int i = 0; i < budget && bus.level != 0; i++) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("drain_done_level", 72'(bus.level), 72'd0);
  endtask

  initial begin
    rst                      = 1'b1;
    bus.debug_reg_write_en   = 1'b0;
    bus.debug_reg_write_addr = 5'd0;
    bus.debug_reg_write_data = 32'd0;
    bus.debug_pc_addr        = 32'd0;
    bus.out_ready            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_level", 72'(bus.level), 72'd0);
    chk("rst_valid", 72'(bus.out_valid), 72'd0);
    chk("rst_fields", 72'({bus.out_pc, bus.out_addr, bus.out_data}), 72'd0);
    chk("rst_drop", 72'(bus.drop_count), 72'd0);
    chk("rst_halt", 72'(bus.halt), 72'd0);
    chk("rst_state", 72'(bus.dbg_state), 72'd0);

    // Reset mid-stream
    wr(5'd1, 32'h11, 32'h100, 1'b1);
    wr(5'd2, 32'h22, 32'h104, 1'b1);
    wr(5'd3, 32'h33, 32'h108, 1'b1);
    chk("mid_level_before", 72'(bus.level), 72'd3);
    pulse_reset();
    chk("mid_level", 72'(bus.level), 72'd0);
    chk("mid_valid", 72'(bus.out_valid), 72'd0);
    chk("mid_drop", 72'(bus.drop_count), 72'd0);
    chk("mid_halt", 72'(bus.halt), 72'd0);

    // Single write, held head, single pop
    wr(5'd8, 32'h12345678, 32'hBFC00010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("single_valid", 72'(bus.out_valid), 72'd1);
      chk("single_fields", 72'({bus.out_pc, bus.out_addr, bus.out_data}),
          72'({32'hBFC00010, 5'd8, 32'h12345678}));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("single_after_valid", 72'(bus.out_valid), 72'd0);
    chk("single_after_level", 72'(bus.level), 72'd0);

    // $0 filter
    for (int i = 0; i < 10; i++) wr(5'd0, 32'(i), 32'h200 + 32'(4 * i), 1'b0);
    chk("zero_level", 72'(bus.level), 72'd0);
    chk("zero_drop", 72'(bus.drop_count), 72'd0);
    chk("zero_valid", 72'(bus.out_valid), 72'd0);

    // Overflow: 20 writes into 16 entries, last four dropped
    for (int i = 0; i < 20; i++) wr(5'd5, 32'(i), 32'h1000 + 32'(4 * i), i < 16);
    chk("ovf_level", 72'(bus.level), 72'd16);
    chk("ovf_drop", 72'(bus.drop_count), 72'd4);
    drain(40);
    chk("ovf_queue_empty", 72'(exp_q.size()), 72'd0);

    // Full with simultaneous pop and capture, then pointer wrap
    for (int i = 0; i < 16; i++) wr(5'd6, 32'h100 + 32'(i), 32'h2000 + 32'(4 * i), 1'b1);
    chk("full_level", 72'(bus.level), 72'd16);
    bus.out_ready = 1'b1;
    wr(5'd9, 32'h200, 32'h3000, 1'b1);
    chk("fullsim_level", 72'(bus.level), 72'd16);
    chk("fullsim_drop", 72'(bus.drop_count), 72'd4);
    for (int i = 1; i <= 40; i++) wr(5'd9, 32'h200 + 32'(i), 32'h3000 + 32'(4 * i), 1'b1);
    bus.out_ready = 1'b0;
    chk("wrap_level", 72'(bus.level), 72'd16);
    chk("wrap_drop", 72'(bus.drop_count), 72'd4);
    drain(40);
    chk("wrap_queue_empty", 72'(exp_q.size()), 72'd0);

    // Sentinel
    pulse_reset();
    wr(5'd4, 32'd1, 32'h4000, 1'b1);
    wr(5'd4, 32'd2, 32'h4004, 1'b1);
    wr(5'd4, HALT_DATA, 32'h4008, 1'b1);
    wr(5'd4, 32'd7, 32'h400C, 1'b0);
    chk("sent_level", 72'(bus.level), 72'd3);
    chk("sent_state", 72'(bus.dbg_state), 72'd1);
    chk("sent_halt_early", 72'(bus.halt), 72'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && bus.level != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("sent_drained", 72'(bus.level), 72'd0);
    chk("sent_halt_at_empty", 72'(bus.halt), 72'd0);
    @(posedge clk); #1;
    chk("sent_halt", 72'(bus.halt), 72'd1);
    chk("sent_state_done", 72'(bus.dbg_state), 72'd2);
    chk("sent_drop", 72'(bus.drop_count), 72'd0);
    chk("sent_queue_empty", 72'(exp_q.size()), 72'd0);
    wr(5'd4, 32'd9, 32'h4010, 1'b0);
    chk("done_ignore_level", 72'(bus.level), 72'd0);
    chk("done_halt_hold", 72'(bus.halt), 72'd1);
    bus.out_ready = 1'b0;

    // Report
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
Sits directly downstream of the core's debug writeback port (debug_reg_write_en/addr/data, debug_pc_addr) and captures every architectural register write as a trace record.
Records are buffered in a first-word-fall-through FIFO and drained over a valid/ready interface to a trace consumer, either a bench comparator or a serializer.
The block also detects the end-of-program sentinel write and raises halt once every record up to and including the sentinel has been drained.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
HALT_DATA, 32'habcd0000, writeback data value that marks end of program
DROP_W, 16, width of the dropped-record counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
debug_reg_write_en  input  1  core writeback enable
debug_reg_write_addr  input  5  writeback register index
debug_reg_write_data  input  32  writeback data
debug_pc_addr  input  32  PC of the writing instruction
out_valid  output  1  head record available
out_ready  input  1  consumer accepts head record
out_pc  output  32  head record PC
out_addr  output  5  head record register index
out_data  output  32  head record data
level  output  clog2(DEPTH)+1  current FIFO occupancy
drop_count  output  DROP_W  records lost to overflow, saturating
halt  output  1  sentinel seen and FIFO fully drained

Behaviour:
- Reset (rst=1 sampled on a rising clk):
  - Pointers, level, drop_count and halt return to 0; state returns to RUN.
  - out_valid=0; out_pc, out_addr and out_data read 0.
  - A reset asserted mid-operation discards all buffered records; no partial pop occurs.
- Capture condition: debug_reg_write_en=1 AND debug_reg_write_addr!=0 AND state==RUN. Writes to $0 are never recorded.
- Push: a captured record {pc, addr, data} is written at the tail on the same rising edge.
- Latency: a record captured at edge N makes out_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty. There is no bypass path.
- Head outputs: out_pc, out_addr and out_data present the head entry whenever out_valid=1. They read 0 when empty.
- Pop: occurs on a rising edge with out_valid=1 and out_ready=1. out_ready is ignored when empty.
- Handshake rule: the head fields hold stable while out_valid=1 and out_ready=0.
- Full: level==DEPTH.
  - A capture while full and not popping that cycle is dropped, and drop_count increments, saturating at all-ones.
  - A capture while full with a pop in the same cycle is accepted; level is unchanged.
- Empty with a simultaneous push and pop: the pop is not performed because out_valid=0. The push lands and level becomes 1.
- Pointer arithmetic: clog2(DEPTH)-bit pointers wrap modulo DEPTH. level equals pushes minus pops and never exceeds DEPTH.
- State machine:
  - RUN: capture enabled. A captured record with data==HALT_DATA is pushed, even if it is the record that fills the FIFO; the state then goes to DRAIN.
  - If the sentinel record is dropped for overflow, it still counts as a drop, and the transition to DRAIN still occurs.
  - DRAIN: all further captures are ignored and are not counted as drops. When level reaches 0, go to DONE.
  - DONE: halt=1, held until reset. Captures are ignored.
- halt is registered: it asserts in the cycle after the FIFO first becomes empty in DRAIN.

Test Plan:
- Reset mid-stream: push 3 records, assert rst for 1 cycle -> level=0, out_valid=0, drop_count=0, halt=0 in the next cycle.
- Single write: en=1, addr=8, data=0x12345678, pc=0xBFC00010 at edge N with out_ready=0 -> out_valid=1 in cycle N+1 with those fields. They stay stable for 5 cycles; after out_ready=1 for one edge, out_valid=0 and level=0.
- $0 filter: 10 consecutive writes with addr=0 -> level stays 0, drop_count=0.
- Overflow, DEPTH=16, out_ready=0: 20 valid writes with data=0..19 -> level=16, drop_count=4. Draining yields data 0..15 in order.
- Full simultaneous: FIFO full, out_ready=1 and a capture in the same cycle -> level stays 16, drop_count unchanged, new record appears at the tail. Verify pointer wrap by continuing for 40 cycles; order must be preserved.
- Sentinel: writes with data 1, 2, 0xabcd0000, then 7, with out_ready=0 -> level=3 and the state is DRAIN. Release out_ready -> records pop in order 1, 2, 0xabcd0000, and halt=1 one cycle after level=0. The write of 7 never appears and drop_count=0.
